libv_base_sdiv_seq: RTL
=======================

Name: libv_base_sdiv_seq

Overview:
Sequential restoring divider with a saturating quotient. It is the inverse-arithmetic companion of the registered saturating adder in the libv_base arithmetic set. It accepts a dividend and divisor under the same clock-enable (ena) strobe scheme and produces the quotient and remainder one bit per enabled cycle. Used where a divide is needed at low rate and area matters more than latency.

Parameters:
AW, 5, dividend width (bits); also the number of iteration steps.
BW, 3, divisor width and remainder width (bits).
OW, 4, quotient output width (bits); a full quotient wider than OW is saturated or truncated (see Optional Feature).

Ports:
clk    in   1    system clock, rising edge.
rst    in   1    asynchronous, active-high reset.
ena    in   1    clock enable; state advances only on edges where ena=1, except DONE->IDLE.
start  in   1    request; sampled only when ena=1 and state=IDLE.
a      in   AW   dividend, unsigned; captured on the accepting edge.
b      in   BW   divisor, unsigned; captured on the accepting edge.
busy   out  1    1 while state is CALC or DONE.
vld    out  1    one-clk pulse; o, r and dz are valid and updated.
o      out  OW   quotient, registered; holds until the next vld.
r      out  BW   remainder, registered; holds until the next vld.
dz     out  1    divide-by-zero flag for the current result; holds with o.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, vld=0, o=0, r=0, dz=0; step counter=0; internal dividend, quotient and remainder registers cleared.
- States:
  - IDLE:
    - start=1 with ena=1 and b!=0: load a and b, remainder=0, counter=AW-1, go to CALC.
    - start=1 with ena=1 and b==0: go to DONE with o=all ones, r=0, dz=1.
  - CALC, on each ena=1 edge:
    - remainder = {remainder, dividend MSB}, width BW+1.
    - If remainder >= b: subtract b and shift quotient bit 1; else shift 0.
    - Shift the dividend left by one.
    - When counter==0, go to DONE; else decrement counter.
    - Edges with ena=0: all registers hold.
  - DONE:
    - On the edge entering DONE, o, r and dz are registered.
    - vld=1 for exactly one clk cycle while in DONE.
    - Next clk edge returns to IDLE regardless of ena.
- Latency: AW enabled edges after the accepting edge, the result is registered. With ena tied to 1, vld is high in the cycle after edge AW. The next start can be accepted on the first ena=1 edge in IDLE after vld.
- Quotient width: the internal quotient is AW bits; overflow past OW bits is handled per the Optional Feature. The remainder always fits in BW bits.
- Boundary conditions:
  - start while busy: ignored, no queueing.
  - start with ena=0: ignored.
  - a=0: o=0, r=0, full latency.
  - b=1: r=0.
  - Reset mid-CALC: aborts immediately, no vld, outputs return to 0.
  - a and b changing after acceptance: no effect on the result.

Optional Feature:
Macro LIBV_SDIV_SAT_EN.
- Defined: if the AW-bit quotient exceeds 2^OW-1, o = 2^OW-1 (all ones).
- Undefined: o = quotient[OW-1:0], i.e. truncation modulo 2^OW.
- Divide-by-zero output (o all ones, dz=1) is identical in both builds.
- If OW>=AW, both builds produce the zero-extended quotient.

Test Plan:
1. ena=1 constantly; start with a=23, b=5 -> vld in the cycle after edge 5; o=4, r=3, dz=0, busy=1 for 6 cycles.
2. ena pulses high one clk in four; start with a=23, b=5 on an ena edge -> vld 20 clk later; o=4, r=3. Inputs changed mid-run have no effect.
3. a=20, b=1 -> r=0. With LIBV_SDIV_SAT_EN: o=15. Without: o=4.
4. a=9, b=0 -> vld on the next edge after acceptance; o=15, r=0, dz=1. The next divide a=6, b=3 -> o=2, r=0, dz=0.
5. start with a=31, b=7 while busy (second start at CALC step 2) -> only the first result appears: o=4, r=3, with a single vld pulse.
6. rst pulsed during CALC step 3 -> o, r, dz, busy, vld all 0 asynchronously; no vld follows. A fresh start with a=7, b=2 -> o=3, r=1.

Source files
------------

// File: rtl/libv_base_sdiv_seq.sv
// libv_base_sdiv_seq: sequential restoring divider, one quotient bit per ena edge.
// Build option LIBV_SDIV_SAT_EN: saturate the quotient to OW bits instead of truncating.
module libv_base_sdiv_seq #(
    parameter int AW = 5,
    parameter int BW = 3,
    parameter int OW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          start,
    input  logic [AW-1:0] a,
    input  logic [BW-1:0] b,
    output logic          busy,
    output logic          vld,
    output logic [OW-1:0] o,
    output logic [BW-1:0] r,
    output logic          dz
);

    localparam int CW = (AW > 1) ? $clog2(AW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] dvd_q, dvd_d;
    logic [BW-1:0] dsr_q, dsr_d;
    logic [AW-1:0] quo_q, quo_d;
    logic [BW-1:0] rem_q, rem_d;
    logic [OW-1:0] o_q, o_d;
    logic [BW-1:0] r_q, r_d;
    logic          dz_q, dz_d;
    logic [BW:0]   trial;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: DONE always falls back to IDLE, other moves need ena
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ena && start) begin
                    state_d = (b != '0) ? CALC : DONE;
                end
            end
            CALC: begin
                if (ena && (cnt_q == '0)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // status outputs decoded from the state
    always_comb begin
        busy = (state_q == CALC) || (state_q == DONE);
        vld  = (state_q == DONE);
    end

    // datapath: operand capture, shift/subtract step, result capture
    always_comb begin
        cnt_d = cnt_q;
        dvd_d = dvd_q;
        dsr_d = dsr_q;
        quo_d = quo_q;
        rem_d = rem_q;
        o_d   = o_q;
        r_d   = r_q;
        dz_d  = dz_q;
        trial = {rem_q, dvd_q[AW-1]};
        unique case (state_q)
            IDLE: begin
                if (ena && start) begin
                    if (b != '0) begin
                        dvd_d = a;
                        dsr_d = b;
                        quo_d = '0;
                        rem_d = '0;
                        cnt_d = CW'(AW - 1);
                    end else begin
                        o_d  = '1;
                        r_d  = '0;
                        dz_d = 1'b1;
                    end
                end
            end
            CALC: begin
                if (ena) begin
                    if (trial >= {1'b0, dsr_q}) begin
                        rem_d = BW'(trial - {1'b0, dsr_q});
                        quo_d = {quo_q[AW-2:0], 1'b1};
                    end else begin
                        rem_d = trial[BW-1:0];
                        quo_d = {quo_q[AW-2:0], 1'b0};
                    end
                    dvd_d = dvd_q << 1;
                    if (cnt_q == '0) begin
                        r_d  = rem_d;
                        dz_d = 1'b0;
`ifdef LIBV_SDIV_SAT_EN
                        if ((AW+OW)'(quo_d) > (AW+OW)'({OW{1'b1}})) begin
                            o_d = '1;
                        end else begin
                            o_d = OW'(quo_d);
                        end
`else
                        o_d = OW'(quo_d);
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dvd_q <= '0;
            dsr_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            o_q   <= '0;
            r_q   <= '0;
            dz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dvd_q <= dvd_d;
            dsr_q <= dsr_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            o_q   <= o_d;
            r_q   <= r_d;
            dz_q  <= dz_d;
        end
    end

    assign o  = o_q;
    assign r  = r_q;
    assign dz = dz_q;

endmodule
